// File: rtl/pong_pkg.sv
// Shared types and fixed screen geometry for the Pong pixel generator.
package pong_pkg;

    localparam int unsigned CW    = 10;
    localparam int unsigned RGB_W = 12;
    localparam int unsigned MC_W  = 4;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        MISS
    } state_t;

    localparam logic [CW-1:0] SCR_H    = 10'd480;
    localparam logic [CW-1:0] TICK_Y   = 10'd481;
    localparam logic [CW-1:0] WALL_X0  = 10'd32;
    localparam logic [CW-1:0] WALL_X1  = 10'd35;
    localparam logic [CW-1:0] PAD_X0   = 10'd600;
    localparam logic [CW-1:0] PAD_X1   = 10'd603;
    localparam logic [CW-1:0] BALL_SZ  = 10'd8;
    localparam logic [CW-1:0] BALL_END = BALL_SZ - 10'd1;
    localparam logic [CW-1:0] BALL_X0  = 10'd316;
    localparam logic [CW-1:0] BALL_Y0  = 10'd236;
    localparam logic [CW-1:0] PAD_Y0   = 10'd204;
    localparam logic [CW-1:0] MISS_X   = 10'd632;

    localparam logic [RGB_W-1:0] COL_BLACK = 12'h000;
    localparam logic [RGB_W-1:0] COL_WALL  = 12'h00F;
    localparam logic [RGB_W-1:0] COL_PAD   = 12'h0F0;
    localparam logic [RGB_W-1:0] COL_BALL  = 12'hF00;

    // Inclusive range test used by the pixel and collision logic.
    function automatic logic in_range(input logic [CW-1:0] v,
                                      input logic [CW-1:0] lo,
                                      input logic [CW-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pong_frame_tick.sv
// One-clk pulse per frame on entry to the (0,481) coordinate; coords are held for several clks.
module pong_frame_tick
    import pong_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] pixel_x,
    input  logic [CW-1:0] pixel_y,
    output logic          refr_tick
);

    logic at_tick_c;
    logic at_tick_q;

    assign at_tick_c = (pixel_y == TICK_Y) && (pixel_x == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            at_tick_q <= 1'b0;
            refr_tick <= 1'b0;
        end else begin
            at_tick_q <= at_tick_c;
            refr_tick <= at_tick_c & ~at_tick_q;
        end
    end

endmodule

// File: rtl/pong_pixel_gen.sv
// Pong game state (paddle, ball, serve/play/miss) updated per frame, and the registered RGB pixel mux.
module pong_pixel_gen
    import pong_pkg::*;
#(
    parameter int unsigned PAD_H       = 72,
    parameter int unsigned PAD_V       = 4,
    parameter int unsigned BALL_V      = 2,
    parameter int unsigned MISS_FRAMES = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    pixel_x,
    input  logic [CW-1:0]    pixel_y,
    input  logic             video_on,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             btn_srv,
    output logic [RGB_W-1:0] rgb,
    output logic [MC_W-1:0]  miss_cnt
);

    localparam int unsigned FW = $clog2(MISS_FRAMES + 1);

    localparam logic [CW-1:0] PAD_STEP  = CW'(PAD_V);
    localparam logic [CW-1:0] BV        = CW'(BALL_V);
    localparam logic [CW-1:0] PAD_END   = CW'(PAD_H - 1);
    localparam logic [CW-1:0] PAD_Y_MAX = SCR_H - CW'(PAD_H);
    localparam logic [CW-1:0] Y_BOT     = SCR_H - BALL_SZ;
    localparam logic [CW-1:0] WALL_STOP = WALL_X1 + 10'd1;
    localparam logic [CW-1:0] PAD_STOP  = PAD_X0 - BALL_SZ;

    logic             refr_tick;
    state_t           state, state_nxt;
    logic [CW-1:0]    pad_y, pad_y_nxt;
    logic [CW-1:0]    ball_x, ball_x_nxt;
    logic [CW-1:0]    ball_y, ball_y_nxt;
    logic             vx_pos, vx_pos_nxt;
    logic             vy_pos, vy_pos_nxt;
    logic [MC_W-1:0]  miss_cnt_nxt;
    logic [FW-1:0]    miss_frm, miss_frm_nxt;
    logic [CW-1:0]    mx, my;
    logic             on_wall, on_pad, on_ball;
    logic [RGB_W-1:0] rgb_nxt;

    pong_frame_tick u_tick (
        .clk      (clk),
        .rst      (rst),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .refr_tick(refr_tick)
    );

    // Paddle: one step per tick, clamped to the screen; conflicting buttons hold.
    always_comb begin
        pad_y_nxt = pad_y;
        if (refr_tick && (btn_up != btn_dn)) begin
            if (btn_up) begin
                pad_y_nxt = (pad_y < PAD_STEP) ? '0 : pad_y - PAD_STEP;
            end else begin
                pad_y_nxt = (pad_y > PAD_Y_MAX - PAD_STEP) ? PAD_Y_MAX : pad_y + PAD_STEP;
            end
        end
    end

    // Ball motion and serve/play/miss sequencing; vertical bounce resolves before horizontal.
    always_comb begin
        state_nxt    = state;
        ball_x_nxt   = ball_x;
        ball_y_nxt   = ball_y;
        vx_pos_nxt   = vx_pos;
        vy_pos_nxt   = vy_pos;
        miss_cnt_nxt = miss_cnt;
        miss_frm_nxt = miss_frm;
        mx           = ball_x + BV;
        my           = ball_y + BV;
        if (refr_tick) begin
            case (state)
                SERVE: begin
                    ball_x_nxt = BALL_X0;
                    ball_y_nxt = BALL_Y0;
                    if (btn_srv) begin
                        state_nxt  = PLAY;
                        vx_pos_nxt = 1'b0;
                        vy_pos_nxt = 1'b1;
                    end
                end
                PLAY: begin
                    if (!vy_pos) begin
                        if (ball_y <= BV + BV) begin
                            ball_y_nxt = '0;
                            vy_pos_nxt = 1'b1;
                        end else begin
                            ball_y_nxt = ball_y - BV;
                        end
                    end else if (my >= Y_BOT - BV) begin
                        ball_y_nxt = Y_BOT;
                        vy_pos_nxt = 1'b0;
                    end else begin
                        ball_y_nxt = my;
                    end

                    if (!vx_pos) begin
                        if (ball_x <= WALL_STOP + BV + BV) begin
                            ball_x_nxt = WALL_STOP;
                            vx_pos_nxt = 1'b1;
                        end else begin
                            ball_x_nxt = ball_x - BV;
                        end
                    end else begin
                        ball_x_nxt = mx;
                        if (in_range(mx + BALL_END, PAD_X0, PAD_X1 + BV) &&
                            (ball_y_nxt + BALL_END >= pad_y) &&
                            (ball_y_nxt <= pad_y + PAD_END)) begin
                            ball_x_nxt = PAD_STOP;
                            vx_pos_nxt = 1'b0;
                        end else if (mx >= MISS_X) begin
                            state_nxt    = MISS;
                            miss_cnt_nxt = miss_cnt + 4'd1;
                            miss_frm_nxt = '0;
                        end
                    end
                end
                MISS: begin
                    if (miss_frm == FW'(MISS_FRAMES - 1)) begin
                        state_nxt    = SERVE;
                        miss_frm_nxt = '0;
                        ball_x_nxt   = BALL_X0;
                        ball_y_nxt   = BALL_Y0;
                    end else begin
                        miss_frm_nxt = miss_frm + FW'(1);
                    end
                end
                default: state_nxt = SERVE;
            endcase
        end
    end

    // Pixel colour from registered game state; first match wins.
    always_comb begin
        on_wall = in_range(pixel_x, WALL_X0, WALL_X1);
        on_pad  = in_range(pixel_x, PAD_X0, PAD_X1) && in_range(pixel_y, pad_y, pad_y + PAD_END);
        on_ball = (state != MISS) &&
                  in_range(pixel_x, ball_x, ball_x + BALL_END) &&
                  in_range(pixel_y, ball_y, ball_y + BALL_END);
        rgb_nxt = COL_BLACK;
        if (!video_on) begin
            rgb_nxt = COL_BLACK;
        end else if (on_wall) begin
            rgb_nxt = COL_WALL;
        end else if (on_pad) begin
            rgb_nxt = COL_PAD;
        end else if (on_ball) begin
            rgb_nxt = COL_BALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SERVE;
            pad_y    <= PAD_Y0;
            ball_x   <= BALL_X0;
            ball_y   <= BALL_Y0;
            vx_pos   <= 1'b1;
            vy_pos   <= 1'b1;
            miss_cnt <= '0;
            miss_frm <= '0;
            rgb      <= COL_BLACK;
        end else begin
            state    <= state_nxt;
            pad_y    <= pad_y_nxt;
            ball_x   <= ball_x_nxt;
            ball_y   <= ball_y_nxt;
            vx_pos   <= vx_pos_nxt;
            vy_pos   <= vy_pos_nxt;
            miss_cnt <= miss_cnt_nxt;
            miss_frm <= miss_frm_nxt;
            rgb      <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Directed bench for pong_pixel_gen: coordinates are jumped straight to the tick row to keep frames short.
module tb_pong_pixel_gen;
    import pong_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, btn_up, btn_dn, btn_srv;
    logic [11:0] rgb;
    logic [3:0]  miss_cnt;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int bad_tick = 0;

    pong_pixel_gen dut (
        .clk     (clk),
        .rst     (rst),
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .video_on(video_on),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .btn_srv (btn_srv),
        .rgb     (rgb),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.refr_tick === 1'b1) begin
            tick_cnt++;
            if (pixel_x !== 10'd0 || pixel_y !== 10'd481) bad_tick++;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One frame: end of last line, then tick row held for 8 clks, all in blanking.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            video_on = 1'b0;
            pixel_x = 10'd799; pixel_y = 10'd480; repeat (4) @(negedge clk);
            pixel_x = 10'd0;   pixel_y = 10'd481; repeat (4) @(negedge clk);
            pixel_x = 10'd1;                      repeat (4) @(negedge clk);
        end
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic von);
        pixel_x = x; pixel_y = y; video_on = von;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        btn_up = 1'b0; btn_dn = 1'b0; btn_srv = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", rgb); end
        checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL reset_miss got %0d want 0", miss_cnt); end
        rst = 1'b0;
        frames(2);
        checks++; if (dut.pad_y !== 10'd204) begin errors++; $display("FAIL reset_pad got %0d want 204", dut.pad_y); end
        checks++; if (dut.state !== SERVE) begin errors++; $display("FAIL reset_state got %0d want SERVE", dut.state); end
        probe(10'd34, 10'd100, 1'b0);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_rgb got %h want 000", rgb); end
        probe(10'd34, 10'd100, 1'b1);
        checks++; if (rgb !== 12'h00F) begin errors++; $display("FAIL wall_rgb got %h want 00F", rgb); end
        probe(10'd601, 10'd210, 1'b1);
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL pad_rgb got %h want 0F0", rgb); end
        probe(10'd320, 10'd240, 1'b1);
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL ball_rgb got %h want F00", rgb); end
        probe(10'd100, 10'd100, 1'b1);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL bg_rgb got %h want 000", rgb); end
        checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL idle_miss got %0d want 0", miss_cnt); end
    endtask

    task automatic test_tick;
        int t0, b0;
        t0 = tick_cnt; b0 = bad_tick;
        frames(3);
        checks++; if (tick_cnt - t0 !== 3) begin errors++; $display("FAIL tick_count got %0d want 3", tick_cnt - t0); end
        checks++; if (bad_tick !== b0) begin errors++; $display("FAIL tick_coord got %0d off-position want 0", bad_tick - b0); end
    endtask

    task automatic test_paddle;
        btn_up = 1'b1;
        frames(10);
        checks++; if (dut.pad_y !== 10'd164) begin errors++; $display("FAIL pad_up10 got %0d want 164", dut.pad_y); end
        frames(50);
        checks++; if (dut.pad_y !== 10'd0) begin errors++; $display("FAIL pad_floor got %0d want 0", dut.pad_y); end
        btn_dn = 1'b1;
        frames(3);
        checks++; if (dut.pad_y !== 10'd0) begin errors++; $display("FAIL pad_both got %0d want 0", dut.pad_y); end
        btn_up = 1'b0;
        frames(1);
        checks++; if (dut.pad_y !== 10'd4) begin errors++; $display("FAIL pad_dn1 got %0d want 4", dut.pad_y); end
        frames(110);
        checks++; if (dut.pad_y !== 10'd408) begin errors++; $display("FAIL pad_ceiling got %0d want 408", dut.pad_y); end
        btn_dn = 1'b0;
        probe(10'd602, 10'd479, 1'b1);
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL pad_bottom_rgb got %h want 0F0", rgb); end
    endtask

    task automatic test_wall_bounce;
        btn_srv = 1'b1;
        frames(1);
        btn_srv = 1'b0;
        checks++; if (dut.state !== PLAY) begin errors++; $display("FAIL serve_state got %0d want PLAY", dut.state); end
        checks++; if (dut.vx_pos !== 1'b0 || dut.ball_x !== 10'd316) begin errors++; $display("FAIL serve_ball got x=%0d vxp=%0d want 316/0", dut.ball_x, dut.vx_pos); end
        frames(116);
        checks++; if (dut.ball_y !== 10'd468 || dut.vy_pos !== 1'b1) begin errors++; $display("FAIL pre_bottom got y=%0d vyp=%0d want 468/1", dut.ball_y, dut.vy_pos); end
        frames(1);
        checks++; if (dut.ball_y !== 10'd472 || dut.vy_pos !== 1'b0) begin errors++; $display("FAIL bottom_bounce got y=%0d vyp=%0d want 472/0", dut.ball_y, dut.vy_pos); end
        frames(21);
        checks++; if (dut.ball_x !== 10'd40 || dut.vx_pos !== 1'b0) begin errors++; $display("FAIL pre_wall got x=%0d vxp=%0d want 40/0", dut.ball_x, dut.vx_pos); end
        frames(1);
        checks++; if (dut.ball_x !== 10'd36 || dut.vx_pos !== 1'b1 || dut.ball_y !== 10'd428) begin errors++; $display("FAIL wall_bounce got x=%0d vxp=%0d y=%0d want 36/1/428", dut.ball_x, dut.vx_pos, dut.ball_y); end
        probe(10'd40, 10'd430, 1'b1);
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL wall_ball_rgb got %h want F00", rgb); end
    endtask

    task automatic test_paddle_bounce;
        btn_up = 1'b1;
        frames(77);
        btn_up = 1'b0;
        checks++; if (dut.pad_y !== 10'd100) begin errors++; $display("FAIL pad_park got %0d want 100", dut.pad_y); end
        frames(201);
        checks++; if (dut.ball_x !== 10'd592 || dut.vx_pos !== 1'b1) begin errors++; $display("FAIL pre_pad got x=%0d vxp=%0d want 592/1", dut.ball_x, dut.vx_pos); end
        frames(1);
        checks++; if (dut.ball_x !== 10'd592 || dut.vx_pos !== 1'b0 || dut.ball_y !== 10'd132) begin errors++; $display("FAIL pad_bounce got x=%0d vxp=%0d y=%0d want 592/0/132", dut.ball_x, dut.vx_pos, dut.ball_y); end
        checks++; if (dut.state !== PLAY || miss_cnt !== 4'd0) begin errors++; $display("FAIL pad_no_miss got state=%0d miss=%0d want PLAY/0", dut.state, miss_cnt); end
        probe(10'd595, 10'd135, 1'b1);
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL pad_ball_rgb got %h want F00", rgb); end
        frames(1);
        checks++; if (dut.ball_x !== 10'd590) begin errors++; $display("FAIL post_pad got x=%0d want 590", dut.ball_x); end
    endtask

    task automatic test_miss;
        int t0;
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        btn_up = 1'b1; btn_srv = 1'b1;
        frames(1);
        btn_srv = 1'b0;
        frames(436);
        checks++; if (dut.state !== PLAY || dut.ball_x !== 10'd630 || dut.pad_y !== 10'd0) begin errors++; $display("FAIL pre_miss got state=%0d x=%0d pad=%0d want PLAY/630/0", dut.state, dut.ball_x, dut.pad_y); end
        frames(1);
        checks++; if (dut.state !== MISS || miss_cnt !== 4'd1 || dut.ball_x !== 10'd632) begin errors++; $display("FAIL miss_enter got state=%0d miss=%0d x=%0d want MISS/1/632", dut.state, miss_cnt, dut.ball_x); end
        probe(10'd634, 10'd172, 1'b1);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL miss_hidden got %h want 000", rgb); end
        frames(59);
        checks++; if (dut.state !== MISS) begin errors++; $display("FAIL miss_hold got %0d want MISS", dut.state); end
        frames(1);
        checks++; if (dut.state !== SERVE || dut.ball_x !== 10'd316 || dut.ball_y !== 10'd236) begin errors++; $display("FAIL miss_return got state=%0d x=%0d y=%0d want SERVE/316/236", dut.state, dut.ball_x, dut.ball_y); end
        probe(10'd320, 10'd240, 1'b1);
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL serve_ball_rgb got %h want F00", rgb); end
        btn_srv = 1'b1;
        frames(1);
        btn_srv = 1'b0;
        frames(437);
        checks++; if (dut.state !== MISS || miss_cnt !== 4'd2) begin errors++; $display("FAIL second_miss got state=%0d miss=%0d want MISS/2", dut.state, miss_cnt); end
        frames(10);
        btn_up = 1'b0;
        pixel_x = 10'd320; pixel_y = 10'd240; video_on = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (dut.state !== SERVE || miss_cnt !== 4'd0 || rgb !== 12'h000) begin errors++; $display("FAIL rst_mid_ctl got state=%0d miss=%0d rgb=%h want SERVE/0/000", dut.state, miss_cnt, rgb); end
        checks++; if (dut.pad_y !== 10'd204 || dut.ball_x !== 10'd316 || dut.ball_y !== 10'd236) begin errors++; $display("FAIL rst_mid_pos got pad=%0d x=%0d y=%0d want 204/316/236", dut.pad_y, dut.ball_x, dut.ball_y); end
        checks++; if (dut.vx_pos !== 1'b1 || dut.vy_pos !== 1'b1) begin errors++; $display("FAIL rst_mid_vel got vxp=%0d vyp=%0d want 1/1", dut.vx_pos, dut.vy_pos); end
        @(negedge clk);
        rst = 1'b0;
        t0 = tick_cnt;
        frames(1);
        checks++; if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL rst_tick got %0d want 1", tick_cnt - t0); end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_paddle();
        test_wall_bounce();
        test_paddle_bounce();
        test_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
